// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU bus controller: funct3 op codes, FSM encoding, defaults.
// The optional bus timeout is enabled by defining LSU_TIMEOUT_EN (see lsu_bus_ctrl).
package lsu_pkg;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

   localparam int LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_bus_ctrl_store_align.sv
// Combinational lane logic: byte enables, store-data replication and access legality
// for one load/store request.
module store_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        misalign,
   output logic        illegal
);

   always_comb begin
      be        = 4'b0000;
      wdata_rep = 32'h0000_0000;
      misalign  = 1'b0;
      illegal   = 1'b0;

      case (op)
         OP_B, OP_BU: be = 4'b0001 << addr_lo;
         OP_H, OP_HU: begin
            be       = 4'b0011 << {addr_lo[1], 1'b0};
            misalign = addr_lo[0];
         end
         OP_W: begin
            be       = 4'b1111;
            misalign = |addr_lo;
         end
         default: illegal = 1'b1;
      endcase

      // Unsigned variants only make sense for loads.
      if (we && (op == OP_BU || op == OP_HU)) begin
         illegal = 1'b1;
      end

      if (we) begin
         case (op)
            OP_B:    wdata_rep = {4{wdata[7:0]}};
            OP_H:    wdata_rep = {2{wdata[15:0]}};
            OP_W:    wdata_rep = wdata;
            default: wdata_rep = 32'h0000_0000;
         endcase
      end
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: accepts one core request, checks alignment, runs a req/ack
// bus cycle and returns the raw word. Define LSU_TIMEOUT_EN to abort stalled bus cycles.
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_addr_lo,
   output logic [2:0]  resp_op
);

   // Handshakes: a request transfers on a rising edge where req_valid & req_ready;
   // a bus access transfers on a rising edge where bus_req & bus_ack; resp_valid is a
   // one-cycle pulse with no back-pressure.

   lsu_state_t  state_q;
   logic        we_q;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        in_idle;
   logic        sa_we;
   logic [2:0]  sa_op;
   logic [1:0]  sa_addr_lo;
   logic [31:0] sa_wdata;
   logic [3:0]  sa_be;
   logic [31:0] sa_wdata_rep;
   logic        sa_misalign;
   logic        sa_illegal;
   logic        tmo_hit;

   // One aligner serves both phases: in IDLE it judges the live request for legality,
   // afterwards it drives lanes from the latched request so the bus stays stable.
   assign in_idle    = (state_q == ST_IDLE);
   assign sa_we      = in_idle ? req_we         : we_q;
   assign sa_op      = in_idle ? req_op         : op_q;
   assign sa_addr_lo = in_idle ? req_addr[1:0]  : addr_q[1:0];
   assign sa_wdata   = in_idle ? req_wdata      : wdata_q;

   store_align u_store_align (
      .we        (sa_we),
      .op        (sa_op),
      .addr_lo   (sa_addr_lo),
      .wdata     (sa_wdata),
      .be        (sa_be),
      .wdata_rep (sa_wdata_rep),
      .misalign  (sa_misalign),
      .illegal   (sa_illegal)
   );

   assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
   assign bus_be    = bus_req ? sa_be                 : 4'b0000;
   assign bus_wdata = bus_req ? sa_wdata_rep          : 32'h0000_0000;

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_q;

   // Cleared while idle so it starts from zero on every entry to BUS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= 8'd0;
      end else if (state_q == ST_IDLE) begin
         tmo_cnt_q <= 8'd0;
      end else if (state_q == ST_BUS && !bus_ack) begin
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
   end

   assign tmo_hit = (state_q == ST_BUS) && (tmo_cnt_q == TMO_LAST);
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES[7:0];
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         op_q         <= 3'b000;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         req_ready    <= 1'b1;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= 32'h0000_0000;
         resp_addr_lo <= 2'b00;
         resp_op      <= 3'b000;
      end else begin
         resp_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  op_q      <= req_op;
                  addr_q    <= req_addr;
                  req_ready <= 1'b0;
                  if (sa_misalign || sa_illegal) begin
                     // Rejected accesses skip the bus and report straight away.
                     state_q      <= ST_RESP;
                     resp_valid   <= 1'b1;
                     resp_err     <= 1'b1;
                     resp_rdata   <= 32'h0000_0000;
                     resp_addr_lo <= req_addr[1:0];
                     resp_op      <= req_op;
                  end else begin
                     wdata_q <= req_wdata;
                     state_q <= ST_BUS;
                     bus_req <= 1'b1;
                     bus_we  <= req_we;
                  end
               end
            end
            ST_BUS: begin
               // An ack in the limit cycle completes normally.
               if (bus_ack || tmo_hit) begin
                  state_q      <= ST_RESP;
                  bus_req      <= 1'b0;
                  bus_we       <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_err     <= !bus_ack;
                  resp_rdata   <= (bus_ack && !we_q) ? bus_rdata : 32'h0000_0000;
                  resp_addr_lo <= addr_q[1:0];
                  resp_op      <= op_q;
               end
            end
            ST_RESP: begin
               state_q   <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state_q   <= ST_IDLE;
               req_ready <= 1'b1;
               bus_req   <= 1'b0;
               bus_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed load/store vectors, scoreboard queues for bus and
// response sides. Timeout vectors run only when LSU_TIMEOUT_EN is defined.
module tb_lsu_bus_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_addr_lo;
   logic [2:0]  resp_op;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int bus_cycles = 0;
   int resp_cnt   = 0;

   // {cycle, err, rdata, addr_lo, op}
   logic [69:0] exp_q[$];
   // {we, addr, be, wdata}
   logic [68:0] bus_exp_q[$];
   logic [68:0] cur_bus;
   logic        bus_prev;

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_be       (bus_be),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .resp_addr_lo (resp_addr_lo),
      .resp_op      (resp_op)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         bus_prev = 1'b0;
      end else begin
         if (bus_req) begin
            bus_cycles++;
            if (!bus_prev) begin
               if (bus_exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL bus_unexpected: bus_req rose at cycle %0d with nothing expected", cyc);
               end else begin
                  cur_bus = bus_exp_q.pop_front();
               end
            end
            total++;
            if ({bus_we, bus_addr, bus_be, bus_wdata} !== cur_bus) begin
               bad++;
               $display("FAIL bus_fields: got we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                        bus_we, bus_addr, bus_be, bus_wdata,
                        cur_bus[68], cur_bus[67:36], cur_bus[35:32], cur_bus[31:0]);
            end
         end
         bus_prev = bus_req;

         if (resp_valid) begin
            logic [69:0] e;
            resp_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL resp_unexpected: resp_valid at cycle %0d err=%b rdata=%h", cyc, resp_err, resp_rdata);
            end else begin
               e = exp_q.pop_front();
               if ({32'(cyc), resp_err, resp_rdata, resp_addr_lo, resp_op} !== e) begin
                  bad++;
                  $display("FAIL resp: got cyc=%0d err=%b rdata=%h lo=%b op=%b want cyc=%0d err=%b rdata=%h lo=%b op=%b",
                           cyc, resp_err, resp_rdata, resp_addr_lo, resp_op,
                           e[69:38], e[37], e[36:5], e[4:3], e[2:0]);
               end
            end
         end
      end
   end

   // driver: one request; w = wait cycles before ack (negative = never ack)
   task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int w, input logic [31:0] rdata,
                          input logic [31:0] e_baddr, input logic [3:0] e_be,
                          input logic [31:0] e_bwd, input logic e_err,
                          input logic [31:0] e_rdata, input int e_lat, input int e_bus_cyc);
      int n;
      int acc;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL ready_wait: req_ready=%b want 1 within 50 cycles", req_ready);
         return;
      end
      bus_cycles = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      acc = cyc;
      req_valid = 1'b0;
      req_wdata = $urandom;
      exp_q.push_back({32'(acc + e_lat - 1), e_err, e_rdata, addr[1:0], op});
      if (e_bus_cyc > 0) bus_exp_q.push_back({we, e_baddr, e_be, e_bwd});
      if (w >= 0) begin
         repeat (w) begin
            @(posedge clk); #1;
         end
         bus_ack   = 1'b1;
         bus_rdata = rdata;
         @(posedge clk); #1;
         bus_ack   = 1'b0;
         bus_rdata = 32'h0;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL resp_timeout: no resp_valid for addr=%h within 300 cycles", addr);
         exp_q.delete();
      end
      total++;
      if (bus_cycles != e_bus_cyc) begin
         bad++;
         $display("FAIL bus_len: addr=%h bus_req cycles=%0d want %0d", addr, bus_cycles, e_bus_cyc);
      end
      @(negedge clk);
      total++;
      if ({resp_valid, resp_err, resp_rdata, resp_addr_lo, resp_op} !== {1'b0, e_err, e_rdata, addr[1:0], op}) begin
         bad++;
         $display("FAIL resp_hold: got v=%b err=%b rdata=%h lo=%b op=%b want v=0 err=%b rdata=%h lo=%b op=%b",
                  resp_valid, resp_err, resp_rdata, resp_addr_lo, resp_op, e_err, e_rdata, addr[1:0], op);
      end
   endtask

   task automatic reset_mid_bus();
      int snap;
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h0000_D000; req_wdata = 32'h0;
      bus_exp_q.push_back({1'b0, 32'h0000_D000, 4'b1111, 32'h0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      total++;
      if ({bus_req, req_ready, resp_valid} !== 3'b010) begin
         bad++;
         $display("FAIL reset_mid_bus: bus_req=%b req_ready=%b resp_valid=%b want 0 1 0", bus_req, req_ready, resp_valid);
      end
      snap = resp_cnt;
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (resp_cnt != snap) begin
         bad++;
         $display("FAIL reset_no_resp: resp pulses after reset=%0d want 0", resp_cnt - snap);
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      bus_prev = 1'b0; cur_bus = '0;
      repeat (2) @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: req_ready=%b want 1", req_ready);
      end
      total++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, resp_valid, resp_err, resp_rdata, resp_addr_lo, resp_op} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: bus_req=%b addr=%h be=%b wdata=%h resp_valid=%b rdata=%h want all 0",
                  bus_req, bus_addr, bus_be, bus_wdata, resp_valid, resp_rdata);
      end
      @(posedge clk); #2;
      reset = 1'b0;

      //      we    op      addr          wdata         w   rdata         baddr         be       bwdata        err   rdata         lat bus
      run_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h1234_5678, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0,        2, 1);
      run_req(1'b0, 3'b001, 32'h0000_2002, 32'h0,         3, 32'hBEEF_1234, 32'h0000_2000, 4'b1100, 32'h0,        1'b0, 32'hBEEF_1234, 5, 4);
      run_req(1'b0, 3'b010, 32'h0000_0001, 32'h0,         0, 32'h5555_5555, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1, 0);
      run_req(1'b1, 3'b100, 32'h0000_3000, 32'h0000_0077, -1, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1, 0);
      run_req(1'b1, 3'b001, 32'h0000_4002, 32'h0000_CAFE, 1, 32'h0,         32'h0000_4000, 4'b1100, 32'hCAFE_CAFE, 1'b0, 32'h0,        3, 2);
      run_req(1'b1, 3'b010, 32'h0000_5000, 32'h1122_3344, 0, 32'hFFFF_FFFF, 32'h0000_5000, 4'b1111, 32'h1122_3344, 1'b0, 32'h0,        2, 1);
      run_req(1'b0, 3'b100, 32'h0000_6001, 32'h0,         2, 32'h89AB_CDEF, 32'h0000_6000, 4'b0010, 32'h0,        1'b0, 32'h89AB_CDEF, 4, 3);
      run_req(1'b0, 3'b101, 32'h0000_7001, 32'h0,        -1, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1, 0);
      run_req(1'b0, 3'b011, 32'h0000_8000, 32'h0,        -1, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1, 0);
      run_req(1'b0, 3'b010, 32'h0000_9004, 32'h0,         0, 32'hDEAD_BEEF, 32'h0000_9004, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF, 2, 1);
      run_req(1'b0, 3'b000, 32'h0000_A002, 32'h0,         0, 32'h0102_0304, 32'h0000_A000, 4'b0100, 32'h0,        1'b0, 32'h0102_0304, 2, 1);
      run_req(1'b1, 3'b001, 32'h0000_B000, 32'h1234_5678, 0, 32'h0,         32'h0000_B000, 4'b0011, 32'h5678_5678, 1'b0, 32'h0,        2, 1);
      run_req(1'b1, 3'b010, 32'h0000_B102, 32'h0,        -1, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1, 0);

      reset_mid_bus();
      run_req(1'b0, 3'b010, 32'h0000_E008, 32'h0,         1, 32'hA1B2_C3D4, 32'h0000_E008, 4'b1111, 32'h0,        1'b0, 32'hA1B2_C3D4, 3, 2);

`ifdef LSU_TIMEOUT_EN
      run_req(1'b0, 3'b010, 32'h0000_C000, 32'h0,        -1, 32'h0,         32'h0000_C000, 4'b1111, 32'h0,        1'b1, 32'h0,        5, 4);
      run_req(1'b0, 3'b010, 32'h0000_C004, 32'h0,         3, 32'h0BAD_F00D, 32'h0000_C004, 4'b1111, 32'h0,        1'b0, 32'h0BAD_F00D, 5, 4);
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
